mem_arbiter_n: RTL and testbench
================================

# mem_arbiter_n

Parametrised N-port memory arbiter, the successor to the two-port instruction/data arbiter. It sits between NPORT requesters (fetch, load/store, debug, DMA …) and the single native memory port. Each port gets a one-entry request buffer, so single-cycle valid pulses are never lost. Grants use either fixed priority or round-robin, and the response is routed back to the port that owns the outstanding access.

## Interface
- NPORT, 2, number of requester ports (2..8)
- AW, 32, address width
- DW, 32, data width; must be a multiple of 8; strobe width SW = DW/8
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- port_valid  in  NPORT  per-port request pulse
- port_instr  in  NPORT  per-port instruction-fetch flag
- port_addr  in  NPORT*AW  packed addresses, port i at [i*AW +: AW]
- port_wdata  in  NPORT*DW  packed write data
- port_wstrb  in  NPORT*SW  packed write strobes; all-zero = read
- port_rdata  out  NPORT*DW  packed read data
- port_ready  out  NPORT  per-port completion
- memory_valid  out  1  request to memory
- memory_instr  out  1  forwarded instr flag
- memory_addr  out  AW  forwarded address
- memory_wdata  out  DW  forwarded write data
- memory_wstrb  out  SW  forwarded strobes
- memory_rdata  in  DW  memory read data
- memory_ready  in  1  memory completion, one pulse per access

## Operation
- State: owner (idle or port index), pend[i] (valid, instr, addr, wdata, wstrb per port), active request register, and rr_ptr (round-robin only).
- Capture: when port_valid[i]=1, pend[i] is loaded from the port inputs in the same cycle. A new pulse while pend[i] is still pending overwrites it (last wins). A port may have at most one request outstanding; a port must not pulse again before it sees port_ready.
- Release: when memory_ready=1, owner becomes idle in that same cycle.
- Grant: when owner is idle after release, pick one port with pend valid. The pick uses the incoming pulse merged into pend.
  - Fixed priority: lowest index wins.
  - Round-robin: search starts at rr_ptr. On a grant to port g, rr_ptr <= (g+1) mod NPORT.
- On grant:
  - The active register is loaded from pend[g], and pend[g] is cleared.
  - owner <= g.
- Memory outputs:
  - While owner is not idle (including the grant cycle), memory_* carries the active request and memory_valid=1.
  - When owner is idle, all memory_* outputs are 0.
  - Request fields are held stable until memory_ready.
- Response routing uses the registered owner:
  - port_ready[owner] = memory_ready, and port_rdata[owner] = memory_rdata.
  - All other ports see ready=0 and rdata=0.
  - A memory_ready with registered owner idle is ignored.

## Timing
- Reset values:
  - memory_valid/instr/addr/wdata/wstrb = 0.
  - port_ready = 0 and port_rdata = 0.
  - owner idle, every pend cleared, rr_ptr = 0.
- Request to memory is combinational: a pulse on an idle arbiter with no other pending request drives memory_valid in the same cycle.
- The response is combinational from memory_ready/memory_rdata to port_ready/port_rdata. There is no added latency.
- Back-to-back accesses:
  - In the cycle memory_ready=1, the next grant is evaluated.
  - memory_valid may stay 1 with the new request's fields while port_ready goes to the previous owner.
  - Zero bubble cycles.
- Simultaneous pulses from k ports are all captured; they are served in k consecutive accesses in arbitration order.
- Reset mid-access drops the outstanding access and all pending requests. A memory_ready arriving after reset is ignored.

## Configuration
- Macro MEM_ARBITER_RR_EN:
  - Defined: round-robin arbitration with rr_ptr.
  - Undefined: fixed priority (lowest index wins) and no rr_ptr register.
- Ports and timing are identical in both builds.

## Test plan
- Reset then idle, NPORT=3: all outputs 0 for 5 cycles. memory_ready=1 with no owner gives port_ready=000.
- Single request: port1 pulses addr=0x100, wstrb=0. Required:
  - memory_valid=1 and addr=0x100 in the same cycle.
  - Memory answers rdata=0xDEADBEEF after 3 cycles; port_ready=010 and port1 rdata=0xDEADBEEF in that cycle only.
- Simultaneous pulses on ports 0, 1, 2, memory ready every 2nd cycle. Required:
  - Fixed build: grant order 0,1,2.
  - RR build with rr_ptr=1 from a prior port-0 access: grant order 1,2,0.
  - No gaps between accesses.
- Starvation check (RR build): ports 0 and 2 re-request immediately after each completion for 20 accesses. Grants must alternate 0,2,0,2…
- Overwrite: port0 pulses addr=0x10, then addr=0x20 while port1 owns memory. Port0's access uses addr 0x20, and only one access is issued for port0.
- Reset asserted while port2's write is outstanding and port0 is pending. After reset: memory_valid=0, memory_ready is ignored, and no port_ready pulse occurs.

Source files
------------

// File: rtl/mem_arbiter_n.sv
// N-port memory arbiter: one-entry request buffer per port, one outstanding memory access, response routed to its owner.
// Define MEM_ARBITER_RR_EN for round-robin grants; the default build grants by fixed priority (lowest index wins).
module mem_arbiter_n #(
    parameter int NPORT = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NPORT-1:0]        port_valid,
    input  logic [NPORT-1:0]        port_instr,
    input  logic [NPORT*AW-1:0]     port_addr,
    input  logic [NPORT*DW-1:0]     port_wdata,
    input  logic [NPORT*(DW/8)-1:0] port_wstrb,
    output logic [NPORT*DW-1:0]     port_rdata,
    output logic [NPORT-1:0]        port_ready,
    output logic                    memory_valid,
    output logic                    memory_instr,
    output logic [AW-1:0]           memory_addr,
    output logic [DW-1:0]           memory_wdata,
    output logic [DW/8-1:0]         memory_wstrb,
    input  logic [DW-1:0]           memory_rdata,
    input  logic                    memory_ready
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(NPORT);

    typedef struct packed {
        logic          instr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t           state, state_next;
    logic [IW-1:0]    owner, owner_next;
    req_t             act_req, act_next;
    logic [NPORT-1:0] pend_valid, pend_valid_next;
    req_t             pend_req      [NPORT];
    req_t             pend_req_next [NPORT];

    logic [NPORT-1:0] merged_valid;
    req_t             merged_req [NPORT];
    logic             grant_found;
    logic [IW-1:0]    grant_idx;
    logic             do_grant;
    logic             owner_done;
    req_t             mem_out;
    int               cand;

`ifdef MEM_ARBITER_RR_EN
    logic [IW-1:0]    rr_ptr, rr_next;
`endif

    // A pulse this cycle takes precedence over the buffered request, so the newest request wins.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            merged_valid[i] = pend_valid[i] | port_valid[i];
            merged_req[i]   = pend_req[i];
            if (port_valid[i]) begin
                merged_req[i] = {port_instr[i], port_addr[i*AW +: AW],
                                 port_wdata[i*DW +: DW], port_wstrb[i*SW +: SW]};
            end
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NPORT; k++) begin
`ifdef MEM_ARBITER_RR_EN
            cand = int'(rr_ptr) + k;
            if (cand >= NPORT) cand = cand - NPORT;
`else
            cand = k;
`endif
            if (!grant_found && merged_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

    // The memory slot frees in the cycle memory_ready arrives, so the next grant costs no bubble.
    assign owner_done = (state == ST_BUSY) && memory_ready;
    assign do_grant   = grant_found && ((state == ST_IDLE) || memory_ready);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next      = state;
        owner_next      = owner;
        act_next        = act_req;
        pend_valid_next = merged_valid;
        for (int i = 0; i < NPORT; i++) begin
            pend_req_next[i] = merged_req[i];
        end
`ifdef MEM_ARBITER_RR_EN
        rr_next = rr_ptr;
`endif
        if (owner_done) begin
            state_next = ST_IDLE;
        end
        if (do_grant) begin
            state_next                 = ST_BUSY;
            owner_next                 = grant_idx;
            act_next                   = merged_req[grant_idx];
            pend_valid_next[grant_idx] = 1'b0;
`ifdef MEM_ARBITER_RR_EN
            rr_next = (grant_idx == IW'(NPORT - 1)) ? '0 : grant_idx + IW'(1);
`endif
        end
    end

    // Outputs are held at zero while reset is low so a stray memory_ready during reset is ignored.
    always_comb begin
        memory_valid = 1'b0;
        mem_out      = '0;
        if (reset) begin
            if (do_grant) begin
                memory_valid = 1'b1;
                mem_out      = merged_req[grant_idx];
            end else if ((state == ST_BUSY) && !memory_ready) begin
                memory_valid = 1'b1;
                mem_out      = act_req;
            end
        end
        memory_instr = mem_out.instr;
        memory_addr  = mem_out.addr;
        memory_wdata = mem_out.wdata;
        memory_wstrb = mem_out.wstrb;
    end

    always_comb begin
        port_ready = '0;
        port_rdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (reset && owner_done && (owner == IW'(i))) begin
                port_ready[i]            = 1'b1;
                port_rdata[i*DW +: DW]   = memory_rdata;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value of the others.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner      <= '0;
            act_req    <= '0;
            pend_valid <= '0;
            // NOTE: the per-port buffers are small and are cleared on reset too, so no stale request survives it.
            for (int i = 0; i < NPORT; i++) begin
                pend_req[i] <= '0;
            end
`ifdef MEM_ARBITER_RR_EN
            rr_ptr <= '0;
`endif
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            act_req    <= act_next;
            pend_valid <= pend_valid_next;
            for (int i = 0; i < NPORT; i++) begin
                pend_req[i] <= pend_req_next[i];
            end
`ifdef MEM_ARBITER_RR_EN
            rr_ptr <= rr_next;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Self-checking bench for mem_arbiter_n (NPORT=3): directed scenarios plus random traffic against a cycle reference model.
// Expectations follow MEM_ARBITER_RR_EN when the bench and design are built with it.
module tb_mem_arbiter_n;

    localparam int NPORT = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [NPORT-1:0]    port_valid = '0;
    logic [NPORT-1:0]    port_instr = '0;
    logic [NPORT*AW-1:0] port_addr  = '0;
    logic [NPORT*DW-1:0] port_wdata = '0;
    logic [NPORT*SW-1:0] port_wstrb = '0;
    logic [NPORT*DW-1:0] port_rdata;
    logic [NPORT-1:0]    port_ready;
    logic                memory_valid;
    logic                memory_instr;
    logic [AW-1:0]       memory_addr;
    logic [DW-1:0]       memory_wdata;
    logic [SW-1:0]       memory_wstrb;
    logic [DW-1:0]       memory_rdata = '0;
    logic                memory_ready = 1'b0;

    always #5 clock = ~clock;

    mem_arbiter_n #(.NPORT(NPORT), .AW(AW), .DW(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .port_valid   (port_valid),
        .port_instr   (port_instr),
        .port_addr    (port_addr),
        .port_wdata   (port_wdata),
        .port_wstrb   (port_wstrb),
        .port_rdata   (port_rdata),
        .port_ready   (port_ready),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_ready (memory_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: buffered requests, current owner (-1 = none), the request in flight, next search start.
    typedef struct packed {
        logic          instr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } rq_t;

    rq_t m_pend [NPORT];
    bit  m_pv   [NPORT];
    int  m_owner = -1;
    rq_t m_act   = '0;
    int  m_rr    = 0;

    task automatic model_cycle();
        rq_t              cand [NPORT];
        bit               cv   [NPORT];
        int               g;
        int               base;
        bit               exp_v;
        rq_t              exp_r;
        logic [NPORT-1:0] exp_rdy;
        logic [NPORT*DW-1:0] exp_rd;
        g = -1; exp_v = 0; exp_r = '0; exp_rdy = '0; exp_rd = '0;
        base = 0;
`ifdef MEM_ARBITER_RR_EN
        base = m_rr;
`endif
        for (int i = 0; i < NPORT; i++) begin
            cv[i]   = m_pv[i] || port_valid[i];
            cand[i] = port_valid[i] ? {port_instr[i], port_addr[i*AW +: AW],
                                       port_wdata[i*DW +: DW], port_wstrb[i*SW +: SW]} : m_pend[i];
        end
        if (reset) begin
            if (m_owner < 0 || memory_ready) begin
                for (int k = 0; k < NPORT; k++) begin
                    if (g < 0 && cv[(base + k) % NPORT]) g = (base + k) % NPORT;
                end
            end
            if (g >= 0) begin
                exp_v = 1; exp_r = cand[g];
            end else if (m_owner >= 0 && !memory_ready) begin
                exp_v = 1; exp_r = m_act;
            end
            if (m_owner >= 0 && memory_ready) begin
                exp_rdy[m_owner] = 1'b1;
                exp_rd[m_owner*DW +: DW] = memory_rdata;
            end
        end
        check("memory_valid", memory_valid, exp_v);
        check("memory_req", {memory_instr, memory_addr, memory_wdata, memory_wstrb}, exp_r);
        check("port_ready", port_ready, exp_rdy);
        check("port_rdata", port_rdata, exp_rd);
        if (!reset) begin
            m_owner = -1; m_rr = 0; m_act = '0;
            for (int i = 0; i < NPORT; i++) begin m_pv[i] = 0; m_pend[i] = '0; end
        end else begin
            if (memory_ready && m_owner >= 0) m_owner = -1;
            for (int i = 0; i < NPORT; i++) begin m_pv[i] = cv[i]; m_pend[i] = cand[i]; end
            if (g >= 0) begin
                m_owner = g; m_act = cand[g]; m_pv[g] = 0; m_rr = (g + 1) % NPORT;
            end
        end
    endtask

    // Memory responder: accepts a request when free, answers mem_lat cycles later with one ready pulse.
    bit               mem_busy  = 0;
    int               mem_cnt   = 0;
    int               mem_lat   = 3;
    bit               rdy_nxt   = 0;
    logic [DW-1:0]    rd_nxt    = '0;
    bit               use_fixed = 0;
    logic [DW-1:0]    fixed_rd  = '0;
    bit               force_rdy = 0;
    logic [NPORT-1:0] outstanding = '0;
    logic [AW-1:0]    acc_log [$];

    always @(negedge clock) begin
        model_cycle();
        if (!reset) begin
            mem_busy = 0;
        end else begin
            if (memory_ready) mem_busy = 0;
            if (memory_valid && !mem_busy) begin
                mem_busy = 1;
                mem_cnt  = mem_lat;
                acc_log.push_back(memory_addr);
            end
        end
        outstanding = outstanding & ~port_ready;
        rdy_nxt = 0;
        if (mem_busy) begin
            mem_cnt--;
            rdy_nxt = (mem_cnt == 0);
        end else if (force_rdy) begin
            rdy_nxt   = 1;
            force_rdy = 0;
        end
        rd_nxt = use_fixed ? fixed_rd : $urandom;
    end

    always @(posedge clock) begin
        #1;
        memory_ready = rdy_nxt;
        memory_rdata = rdy_nxt ? rd_nxt : '0;
    end

    task automatic tick();
        @(posedge clock);
        #1;
        port_valid = '0;
    endtask

    task automatic set_req(input int p, input logic ins, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [SW-1:0] ws);
        port_valid[p]           = 1'b1;
        port_instr[p]           = ins;
        port_addr[p*AW +: AW]   = a;
        port_wdata[p*DW +: DW]  = wd;
        port_wstrb[p*SW +: SW]  = ws;
        outstanding[p]          = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((outstanding != '0 || mem_busy) && n < 400) begin
            tick();
            n++;
        end
        check(tag, {127'd0, (outstanding != '0 || mem_busy)}, 128'd0);
    endtask

    int exp_order [3];

    initial begin
`ifdef MEM_ARBITER_RR_EN
        exp_order = '{1, 2, 0};
`else
        exp_order = '{0, 1, 2};
`endif
        // Reset, then idle with all outputs at zero; a stray memory_ready is ignored.
        repeat (3) tick();
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick(); #3;
            check("idle_valid", memory_valid, 1'b0);
            check("idle_ready", port_ready, 3'b000);
        end
        force_rdy = 1;
        tick(); tick(); #3;
        check("stray_ready", port_ready, 3'b000);

        // Single read from port 1: same-cycle request, answer after three cycles.
        use_fixed = 1; fixed_rd = 32'hDEADBEEF; mem_lat = 3;
        tick();
        set_req(1, 1'b0, 32'h100, 32'h0, 4'h0);
        #3;
        check("single_valid", memory_valid, 1'b1);
        check("single_addr", memory_addr, 32'h100);
        for (int n = 1; n <= 4; n++) begin
            tick(); #3;
            check("single_ready", port_ready, (n == 3) ? 3'b010 : 3'b000);
            if (n == 3) check("single_rdata", port_rdata[1*DW +: DW], 32'hDEADBEEF);
        end
        use_fixed = 0;
        wait_idle("single_done");

        // Port-0 access, then simultaneous pulses on all ports with memory ready every 2nd cycle.
        mem_lat = 2;
        tick();
        set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
        wait_idle("prior_done");
        acc_log.delete();
        tick();
        for (int p = 0; p < NPORT; p++) set_req(p, 1'b0, (p << 12) | 32'h80, 32'h0, 4'h0);
        wait_idle("simul_done");
        check("simul_count", acc_log.size(), 3);
        for (int i = 0; i < 3 && i < acc_log.size(); i++) begin
            check("simul_order", acc_log[i][15:12], exp_order[i]);
        end

        // Ports 0 and 2 re-request right after each completion; grants must alternate.
        acc_log.delete();
        tick();
        set_req(0, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h0000_2200, 32'h0, 4'h0);
        for (int n = 0; n < 600 && acc_log.size() < 20; n++) begin
            tick();
            if (!outstanding[0]) set_req(0, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
            if (!outstanding[2]) set_req(2, 1'b0, 32'h0000_2200, 32'h0, 4'h0);
        end
        wait_idle("starve_done");
        check("starve_count", {127'd0, acc_log.size() >= 20}, 128'd1);
        for (int i = 1; i < 20 && i < acc_log.size(); i++) begin
            check("starve_alt", {127'd0, acc_log[i][15:12] != acc_log[i-1][15:12]}, 128'd1);
        end

        // Overwrite: port 0 pulses twice while port 1 owns memory; only the second request is issued.
        mem_lat = 6;
        acc_log.delete();
        tick();
        set_req(1, 1'b0, 32'h1100, 32'h0, 4'h0);
        tick();
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        tick(); tick();
        set_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_idle("overwrite_done");
        check("overwrite_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("overwrite_first", acc_log[0], 32'h1100);
            check("overwrite_addr", acc_log[1], 32'h20);
        end

        // Reset while port 2's write is outstanding and port 0 is pending.
        mem_lat = 8;
        tick();
        set_req(2, 1'b0, 32'h2200, 32'hCAFE_F00D, 4'hF);
        tick();
        set_req(0, 1'b1, 32'h30, 32'h0, 4'h0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        outstanding = '0;
        #3;
        check("rst_valid", memory_valid, 1'b0);
        force_rdy = 1;
        for (int n = 0; n < 4; n++) begin
            tick(); #3;
            check("rst_valid_after", memory_valid, 1'b0);
            check("rst_ready_after", port_ready, 3'b000);
        end

        // Random traffic with random latency, checked every cycle by the model.
        for (int n = 0; n < 1500; n++) begin
            tick();
            mem_lat = $urandom_range(1, 4);
            for (int p = 0; p < NPORT; p++) begin
                if (!outstanding[p] && $urandom_range(0, 3) == 0) begin
                    set_req(p, 1'(($urandom >> 3) & 1), $urandom, $urandom, 4'($urandom_range(0, 15)));
                end
            end
        end
        wait_idle("random_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
